// File: rtl/i2s_sync_manager.sv
// I2S timing-source manager: selects between the local I2S generator and an
// externally tracked I2S source. Switching happens only on frame boundaries,
// with lock/loss hysteresis and a mute window around every switchover.
module i2s_sync_manager #(
    parameter int LOCK_FRAMES = 4,
    parameter int LOSS_FRAMES = 2,
    parameter int MUTE_FRAMES = 2,
    parameter int ARM_TIMEOUT = 2,
    parameter int CW          = 3
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       ext_valid,
    input  logic       ext_en,
    input  logic [5:0] ext_frame_posn,
    input  logic       local_en,
    input  logic [5:0] local_frame_posn,
    input  logic       force_local,
    output logic       en,
    output logic [5:0] frame_posn,
    output logic       external,
    output logic       mute,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_LOCAL     = 2'd0,
        ST_ARM_EXT   = 2'd1,
        ST_EXT       = 2'd2,
        ST_ARM_LOCAL = 2'd3
    } state_t;

    localparam logic [CW-1:0] LOCK_C = CW'(LOCK_FRAMES);
    localparam logic [CW-1:0] LOSS_C = CW'(LOSS_FRAMES);
    localparam logic [CW-1:0] MUTE_C = CW'(MUTE_FRAMES);
    localparam logic [CW-1:0] TMO_C  = CW'(ARM_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = '1;

    // Counters never wrap: they stick at full scale going up and at zero going down.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (x == CNT_MAX) ? x : x + CW'(1);
    endfunction

    function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] x);
        return (x == '0) ? x : x - CW'(1);
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] lock_cnt, lock_d;
    logic [CW-1:0] loss_cnt, loss_d;
    logic [CW-1:0] tmo_cnt, tmo_d;
    logic [CW-1:0] mute_cnt, mute_d;
    logic          local_sof;
    logic          ext_sof;
    logic          src_ext;

    assign local_sof = local_en & (local_frame_posn == 6'd0);
    assign ext_sof   = ext_en & (ext_frame_posn == 6'd0);

    // Next-state and counter updates; each state acts only on its own trigger event.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_cnt;
        loss_d  = loss_cnt;
        tmo_d   = tmo_cnt;
        mute_d  = mute_cnt;
        case (state_q)
            ST_LOCAL: begin
                if (local_sof)
                    mute_d = sat_dec(mute_cnt);
                if (!ext_valid || force_local)
                    lock_d = '0;
                else if (local_sof)
                    lock_d = sat_inc(lock_cnt);
                if (lock_cnt == LOCK_C) begin
                    state_d = ST_ARM_EXT;
                    tmo_d   = '0;
                end
            end
            ST_ARM_EXT: begin
                if (local_sof)
                    tmo_d = sat_inc(tmo_cnt);
                // Abort outranks a coincident external frame start.
                if (force_local || !ext_valid || (tmo_cnt == TMO_C)) begin
                    state_d = ST_LOCAL;
                    lock_d  = '0;
                end else if (ext_sof) begin
                    state_d = ST_EXT;
                    mute_d  = MUTE_C;
                    loss_d  = '0;
                end
            end
            ST_EXT: begin
                if (ext_sof)
                    mute_d = sat_dec(mute_cnt);
                if (ext_valid)
                    loss_d = '0;
                else if (local_sof)
                    loss_d = sat_inc(loss_cnt);
                if ((loss_cnt == LOSS_C) || force_local)
                    state_d = ST_ARM_LOCAL;
            end
            ST_ARM_LOCAL: begin
                // Local generator is free-running, so waiting for its frame start cannot stall.
                if (local_sof) begin
                    state_d = ST_LOCAL;
                    mute_d  = MUTE_C;
                    lock_d  = '0;
                end
            end
            default: state_d = ST_LOCAL;
        endcase
    end

    // Mux uses the upcoming state so the triggering frame start comes from the new source.
    assign src_ext = (state_d == ST_EXT) || (state_d == ST_ARM_LOCAL);

    // State and counter registers.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q  <= ST_LOCAL;
            lock_cnt <= '0;
            loss_cnt <= '0;
            tmo_cnt  <= '0;
            mute_cnt <= MUTE_C;
        end else begin
            state_q  <= state_d;
            lock_cnt <= lock_d;
            loss_cnt <= loss_d;
            tmo_cnt  <= tmo_d;
            mute_cnt <= mute_d;
        end
    end

    // Registered bit-enable / bit-index selection towards the DSP chain.
    always_ff @(posedge ck) begin
        if (rst) begin
            en         <= 1'b0;
            frame_posn <= 6'd0;
        end else begin
            en         <= src_ext ? ext_en : local_en;
            frame_posn <= src_ext ? ext_frame_posn : local_frame_posn;
        end
    end

    assign external = (state_q == ST_EXT) || (state_q == ST_ARM_LOCAL);
    assign mute     = (state_q == ST_ARM_EXT) || (state_q == ST_ARM_LOCAL) || (mute_cnt != '0);
    assign state    = state_q;

endmodule

// File: tb/tb_i2s_sync_manager.sv
// Directed bench for i2s_sync_manager: walks every state transition,
// hysteresis path, abort path and mid-run reset.
module tb_i2s_sync_manager;

    logic       ck;
    logic       rst;
    logic       ext_valid;
    logic       ext_en;
    logic [5:0] ext_frame_posn;
    logic       local_en;
    logic [5:0] local_frame_posn;
    logic       force_local;
    logic       en;
    logic [5:0] frame_posn;
    logic       external;
    logic       mute;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    i2s_sync_manager dut (
        .ck               (ck),
        .rst              (rst),
        .ext_valid        (ext_valid),
        .ext_en           (ext_en),
        .ext_frame_posn   (ext_frame_posn),
        .local_en         (local_en),
        .local_frame_posn (local_frame_posn),
        .force_local      (force_local),
        .en               (en),
        .frame_posn       (frame_posn),
        .external         (external),
        .mute             (mute),
        .state            (state)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: apply strobes, let the edge happen, then sample 1 time unit later.
    task automatic cyc(input logic le, input logic [5:0] lp, input logic ee, input logic [5:0] ep);
        local_en         = le;
        local_frame_posn = lp;
        ext_en           = ee;
        ext_frame_posn   = ep;
        @(posedge ck);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 6'd9, 1'b0, 6'd9);
    endtask

    task automatic lsof();
        cyc(1'b1, 6'd0, 1'b0, 6'd9);
    endtask

    task automatic esof();
        cyc(1'b0, 6'd3, 1'b1, 6'd0);
    endtask

    task automatic lsof_n(input int n);
        for (int i = 0; i < n; i++) lsof();
    endtask

    initial begin
        rst = 1'b1;
        ext_valid = 1'b0;
        force_local = 1'b0;
        local_en = 1'b0;
        local_frame_posn = 6'd0;
        ext_en = 1'b0;
        ext_frame_posn = 6'd0;

        // Reset state
        idle();
        idle();
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_external", 8'(external), 8'd0);
        chk("rst_en", 8'(en), 8'd0);
        chk("rst_posn", 8'(frame_posn), 8'd0);
        chk("rst_mute", 8'(mute), 8'd1);
        chk("rst_mute_cnt", 8'(dut.mute_cnt), 8'd2);
        rst = 1'b0;

        // Local frames, no external: outputs follow local one cycle late, mute after 2 sof
        lsof();
        chk("loc_en", 8'(en), 8'd1);
        chk("loc_posn0", 8'(frame_posn), 8'd0);
        chk("loc_mute_a", 8'(mute), 8'd1);
        cyc(1'b1, 6'd5, 1'b0, 6'd9);
        chk("loc_posn5", 8'(frame_posn), 8'd5);
        cyc(1'b0, 6'd6, 1'b1, 6'd0);
        chk("loc_ignores_ext_en", 8'(en), 8'd0);
        chk("loc_mute_b", 8'(mute), 8'd1);
        lsof();
        chk("loc_mute_clear", 8'(mute), 8'd0);
        chk("loc_external", 8'(external), 8'd0);
        chk("loc_state", 8'(state), 8'd0);

        // Lock hysteresis, arm, switch to external on its frame start
        ext_valid = 1'b1;
        lsof_n(3);
        chk("lock_cnt3", 8'(dut.lock_cnt), 8'd3);
        lsof();
        chk("lock4_still_local", 8'(state), 8'd0);
        chk("lock4_mute", 8'(mute), 8'd0);
        idle();
        chk("arm_ext_state", 8'(state), 8'd1);
        chk("arm_ext_mute", 8'(mute), 8'd1);
        chk("arm_ext_external", 8'(external), 8'd0);
        esof();
        chk("ext_state", 8'(state), 8'd2);
        chk("ext_external", 8'(external), 8'd1);
        chk("ext_en", 8'(en), 8'd1);
        chk("ext_posn", 8'(frame_posn), 8'd0);
        chk("ext_mute_a", 8'(mute), 8'd1);
        esof();
        chk("ext_mute_b", 8'(mute), 8'd1);
        esof();
        chk("ext_mute_clear", 8'(mute), 8'd0);

        // Loss hysteresis: short dropout recovers, longer one arms fall-back
        ext_valid = 1'b0;
        lsof();
        chk("loss1_state", 8'(state), 8'd2);
        chk("loss1_en_from_ext", 8'(en), 8'd0);
        chk("loss1_cnt", 8'(dut.loss_cnt), 8'd1);
        ext_valid = 1'b1;
        idle();
        chk("loss_cleared", 8'(dut.loss_cnt), 8'd0);
        chk("loss_cleared_state", 8'(state), 8'd2);
        ext_valid = 1'b0;
        lsof_n(2);
        chk("loss2_state", 8'(state), 8'd2);
        idle();
        chk("arm_local_state", 8'(state), 8'd3);
        chk("arm_local_mute", 8'(mute), 8'd1);
        chk("arm_local_external", 8'(external), 8'd1);
        esof();
        chk("arm_local_ignores_esof", 8'(state), 8'd3);
        cyc(1'b1, 6'd0, 1'b1, 6'd4);
        chk("back_local_state", 8'(state), 8'd0);
        chk("back_local_external", 8'(external), 8'd0);
        chk("back_local_en", 8'(en), 8'd1);
        chk("back_local_posn", 8'(frame_posn), 8'd0);
        chk("back_local_mute", 8'(mute), 8'd1);
        lsof_n(2);
        chk("back_local_unmute", 8'(mute), 8'd0);

        // ARM_EXT timeout with no external frame start
        ext_valid = 1'b1;
        lsof_n(4);
        idle();
        chk("tmo_arm", 8'(state), 8'd1);
        lsof_n(2);
        chk("tmo_cnt2_still_arm", 8'(state), 8'd1);
        idle();
        chk("tmo_abort_state", 8'(state), 8'd0);
        chk("tmo_abort_lock", 8'(dut.lock_cnt), 8'd0);
        chk("tmo_abort_external", 8'(external), 8'd0);
        chk("tmo_abort_mute", 8'(mute), 8'd0);

        // ext_valid drop coincides with ext_sof: abort wins
        lsof_n(4);
        idle();
        chk("abort_arm", 8'(state), 8'd1);
        ext_valid = 1'b0;
        esof();
        chk("abort_state", 8'(state), 8'd0);
        chk("abort_external", 8'(external), 8'd0);
        chk("abort_en_local", 8'(en), 8'd0);
        ext_valid = 1'b1;

        // force_local pulse while external
        lsof_n(4);
        idle();
        esof();
        chk("force_pre_ext", 8'(state), 8'd2);
        force_local = 1'b1;
        idle();
        chk("force_arm_local", 8'(state), 8'd3);
        force_local = 1'b0;
        idle();
        chk("force_wait_lsof", 8'(state), 8'd3);
        lsof();
        chk("force_local_state", 8'(state), 8'd0);
        chk("force_local_external", 8'(external), 8'd0);

        // force_local held blocks locking entirely
        force_local = 1'b1;
        lsof_n(5);
        idle();
        chk("force_hold_state", 8'(state), 8'd0);
        chk("force_hold_lock", 8'(dut.lock_cnt), 8'd0);
        force_local = 1'b0;

        // Reset in EXT with mute_cnt=1
        lsof_n(4);
        idle();
        esof();
        esof();
        chk("prerst_state", 8'(state), 8'd2);
        chk("prerst_mute_cnt", 8'(dut.mute_cnt), 8'd1);
        rst = 1'b1;
        cyc(1'b1, 6'd3, 1'b1, 6'd2);
        rst = 1'b0;
        chk("midrst_state", 8'(state), 8'd0);
        chk("midrst_external", 8'(external), 8'd0);
        chk("midrst_en", 8'(en), 8'd0);
        chk("midrst_posn", 8'(frame_posn), 8'd0);
        chk("midrst_mute", 8'(mute), 8'd1);
        chk("midrst_mute_cnt", 8'(dut.mute_cnt), 8'd2);
        chk("midrst_lock", 8'(dut.lock_cnt), 8'd0);
        lsof();
        chk("postrst_en", 8'(en), 8'd1);
        chk("postrst_external", 8'(external), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
